// File: rtl/dpll_control_param_pkg.sv
// Shared types and helpers for the DPLL top-level controller and its decision stack.
package dpll_control_param_pkg;

  localparam int unsigned CYC_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BCP,
    ST_WAIT_BCP,
    ST_DECIDE,
    ST_ASSIGN,
    ST_BT_POP,
    ST_UNDO,
    ST_DONE
  } ctrl_state_t;

  // Index width that never collapses to zero for tiny parameter values.
  function automatic int unsigned width_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dpll_control_param_decision_stack.sv
// LIFO of decision entries {var, val, flipped}; one operation per cycle,
// priority clear > push > pop > flip_top.
module decision_stack
  import dpll_control_param_pkg::*;
#(
  parameter int unsigned VAR_W     = 6,
  parameter int unsigned MAX_DEPTH = 64,
  parameter int unsigned LVL_W     = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic             flip_top,
  input  logic [VAR_W-1:0] push_var,
  input  logic             push_val,
  output logic [VAR_W-1:0] top_var,
  output logic             top_val,
  output logic             top_flipped,
  output logic [LVL_W-1:0] depth,
  output logic             full,
  output logic             empty
);

  localparam int unsigned IDX_W = width_of(MAX_DEPTH);

  typedef struct packed {
    logic [VAR_W-1:0] var_id;
    logic             val;
    logic             flipped;
  } dec_entry_t;

  dec_entry_t       ent_q [MAX_DEPTH];
  dec_entry_t       ent_d [MAX_DEPTH];
  logic [LVL_W-1:0] depth_q, depth_d;
  logic [IDX_W-1:0] top_idx, wr_idx;

  assign top_idx = IDX_W'(depth_q - 1'b1);
  assign wr_idx  = IDX_W'(depth_q);
  assign full    = (depth_q == LVL_W'(MAX_DEPTH));
  assign empty   = (depth_q == '0);
  assign depth   = depth_q;

  assign top_var     = empty ? '0 : ent_q[top_idx].var_id;
  assign top_val     = empty ? 1'b0 : ent_q[top_idx].val;
  assign top_flipped = empty ? 1'b0 : ent_q[top_idx].flipped;

  always_comb begin
    ent_d   = ent_q;
    depth_d = depth_q;
    if (clear) begin
      depth_d = '0;
    end else if (push && !full) begin
      ent_d[wr_idx] = '{var_id: push_var, val: push_val, flipped: 1'b0};
      depth_d       = depth_q + 1'b1;
    end else if (pop && !empty) begin
      depth_d = depth_q - 1'b1;
    end else if (flip_top && !empty) begin
      ent_d[top_idx].val     = ~ent_q[top_idx].val;
      ent_d[top_idx].flipped = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q   <= '{default: '0};
      depth_q <= '0;
    end else begin
      ent_q   <= ent_d;
      depth_q <= depth_d;
    end
  end

endmodule

// File: rtl/dpll_control_param.sv
// DPLL top-level controller: sequences BCP, decide and assign, backtracks
// chronologically over the decision stack, with cycle budget, abort and overflow error.
module dpll_control_param
  import dpll_control_param_pkg::*;
#(
  parameter  int unsigned NUM_VARS   = 64,
  parameter  int unsigned MAX_DEPTH  = 64,
  parameter  int unsigned MAX_CYCLES = 0,
  localparam int unsigned VAR_W      = width_of(NUM_VARS),
  localparam int unsigned LVL_W      = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             bcp_start,
  input  logic             bcp_done,
  input  logic             bcp_conflict,
  output logic             dec_req,
  input  logic             dec_valid,
  input  logic             dec_all_assigned,
  input  logic [VAR_W-1:0] dec_var,
  input  logic             dec_val,
  output logic             asg_valid,
  input  logic             asg_ready,
  output logic [VAR_W-1:0] asg_var,
  output logic             asg_val,
  output logic [LVL_W-1:0] asg_level,
  output logic             undo_valid,
  input  logic             undo_ready,
  output logic [LVL_W-1:0] undo_level,
  output logic             busy,
  output logic             sat,
  output logic             unsat,
  output logic             timeout,
  output logic             error,
  output logic [LVL_W-1:0] cur_level,
  output logic [CYC_W-1:0] cycle_count
);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLES - 1);

  ctrl_state_t      state_q, state_d;
  logic             sat_q, sat_d;
  logic             unsat_q, unsat_d;
  logic             timeout_q, timeout_d;
  logic             error_q, error_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;

  logic             stk_clear, stk_push, stk_pop, stk_flip;
  logic [VAR_W-1:0] stk_top_var;
  logic             stk_top_val, stk_top_flipped;
  logic [LVL_W-1:0] stk_depth;
  logic             stk_full, stk_empty;
  logic             budget_hit;

  decision_stack #(
    .VAR_W     (VAR_W),
    .MAX_DEPTH (MAX_DEPTH),
    .LVL_W     (LVL_W)
  ) u_stack (
    .clk         (clock),
    .rst_n       (reset),
    .clear       (stk_clear),
    .push        (stk_push),
    .pop         (stk_pop),
    .flip_top    (stk_flip),
    .push_var    (dec_var),
    .push_val    (dec_val),
    .top_var     (stk_top_var),
    .top_val     (stk_top_val),
    .top_flipped (stk_top_flipped),
    .depth       (stk_depth),
    .full        (stk_full),
    .empty       (stk_empty)
  );

  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bcp_start  = (state_q == ST_BCP);
  assign dec_req    = (state_q == ST_DECIDE);
  assign asg_valid  = (state_q == ST_ASSIGN);
  assign undo_valid = (state_q == ST_UNDO);

  assign asg_var    = asg_valid ? stk_top_var : '0;
  assign asg_val    = asg_valid & stk_top_val;
  assign asg_level  = asg_valid ? stk_depth : '0;
  assign undo_level = undo_valid ? (stk_depth - 1'b1) : '0;

  assign cur_level   = stk_depth;
  assign cycle_count = cyc_q;
  assign sat         = sat_q;
  assign unsat       = unsat_q;
  assign timeout     = timeout_q;
  assign error       = error_q;

  assign budget_hit = busy && (MAX_CYCLES != 0) && (cyc_q == CYC_LAST);

  always_comb begin
    state_d   = state_q;
    sat_d     = sat_q;
    unsat_d   = unsat_q;
    timeout_d = timeout_q;
    error_d   = error_q;
    cyc_d     = cyc_q;
    stk_clear = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_flip  = 1'b0;

    if (busy && (cyc_q != '1)) cyc_d = cyc_q + 1'b1;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sat_d     = 1'b0;
          unsat_d   = 1'b0;
          timeout_d = 1'b0;
          error_d   = 1'b0;
          cyc_d     = '0;
          stk_clear = 1'b1;
          state_d   = ST_BCP;
        end
      end
      ST_BCP: state_d = ST_WAIT_BCP;
      ST_WAIT_BCP: begin
        if (bcp_done) begin
          if (!bcp_conflict) begin
            state_d = ST_DECIDE;
          end else if (stk_empty) begin
            unsat_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_BT_POP;
          end
        end
      end
      ST_DECIDE: begin
        if (dec_valid) begin
          if (dec_all_assigned) begin
            sat_d   = 1'b1;
            state_d = ST_DONE;
          end else if (stk_full) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            stk_push = 1'b1;
            state_d  = ST_ASSIGN;
          end
        end
      end
      ST_ASSIGN: if (asg_ready) state_d = ST_BCP;
      ST_BT_POP: begin
        // Already-flipped decisions are exhausted; the first unflipped one gets retried.
        if (stk_top_flipped) begin
          stk_pop = 1'b1;
          if (stk_depth == LVL_W'(1)) begin
            unsat_d = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          stk_flip = 1'b1;
          state_d  = ST_UNDO;
        end
      end
      ST_UNDO: if (undo_ready) state_d = ST_ASSIGN;
      default: state_d = ST_IDLE;
    endcase

    // Budget expiry discards any result or stack update decided this cycle.
    if (budget_hit) begin
      state_d   = ST_DONE;
      timeout_d = 1'b1;
      sat_d     = sat_q;
      unsat_d   = unsat_q;
      error_d   = error_q;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      stk_flip  = 1'b0;
    end

    if (abort) begin
      state_d   = ST_IDLE;
      sat_d     = 1'b0;
      unsat_d   = 1'b0;
      timeout_d = 1'b0;
      error_d   = 1'b0;
      cyc_d     = '0;
      stk_clear = 1'b1;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      stk_flip  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sat_q     <= 1'b0;
      unsat_q   <= 1'b0;
      timeout_q <= 1'b0;
      error_q   <= 1'b0;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      sat_q     <= sat_d;
      unsat_q   <= unsat_d;
      timeout_q <= timeout_d;
      error_q   <= error_d;
      cyc_q     <= cyc_d;
    end
  end

endmodule
